// File: rtl/uart_rx_simple.sv
// -----------------------------------------------------------------------------
// uart_rx_simple
//   UART receiver. It brings the asynchronous serial_rx line into the clock
//   domain through a two-flop synchroniser and detects start bits. It samples
//   each bit at its centre and delivers the 8-bit payload with a one-cycle
//   valid strobe and parity/framing error flags.
//
// Parameters
//   CLK_FREQ_HZ : system clock frequency in Hz
//   BAUD_RATE   : line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (>= 4)
//   PARITY      : 0 = none, 1 = odd, 2 = even
//   STOP        : number of stop bits, 1 or 2
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   serial_rx      in   asynchronous serial line, idle high
//   rx_byte        out  last received payload (LSB received first)
//   byte_valid     out  one-cycle strobe: rx_byte / parity_err / frame_err valid
//   receiving_byte out  high from confirmed start bit until frame end
//   parity_err     out  parity mismatch on the frame that raised byte_valid
//   frame_err      out  a stop bit was sampled low on that frame
//   dbg_state      out  current FSM state encoding (state_t), for observation
//
// Handshake: byte_valid is a pure strobe with no back-pressure. rx_byte and
// the flags are held until the next strobe. The consumer must take them
// before the next frame completes.
// -----------------------------------------------------------------------------
module uart_rx_simple #(
  parameter int CLK_FREQ_HZ = 33330000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY      = 0,
  parameter int STOP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       receiving_byte,
  output logic       parity_err,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Last count of a full bit period, and the count at which the start bit
  // centre is reached (half a bit after the synchronised falling edge).
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_rx_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_perr;
  logic             r_ferr;
  logic [7:0]       r_rx_byte;
  logic             r_byte_valid;
  logic             r_receiving;
  logic             r_parity_err;
  logic             r_frame_err;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_perr_nxt;
  logic             w_ferr_nxt;
  logic [7:0]       w_rx_byte_nxt;
  logic             w_byte_valid_nxt;
  logic             w_receiving_nxt;
  logic             w_parity_err_nxt;
  logic             w_frame_err_nxt;
  logic             w_tick;
  logic             w_ferr_now;

  // A full-bit sample point in DATA / PARITY / STOP.
  assign w_tick = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Input synchroniser. It resets to the idle (high) line level so that
  // reset release does not look like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= serial_rx;
      r_rx_s  <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_receiving  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_perr       <= w_perr_nxt;
      r_ferr       <= w_ferr_nxt;
      r_rx_byte    <= w_rx_byte_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_receiving  <= w_receiving_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_perr_nxt       = r_perr;
    w_ferr_nxt       = r_ferr;
    w_rx_byte_nxt    = r_rx_byte;
    w_byte_valid_nxt = 1'b0;
    w_receiving_nxt  = r_receiving;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    w_ferr_now       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      // Check the line again at the start-bit centre. A high level there
      // means the low pulse was a glitch. In that case, return to IDLE
      // without touching any output.
      S_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_receiving_nxt = 1'b1;
            w_bit_idx_nxt   = '0;
            w_state_nxt     = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      // From here on, every tick is one bit centre later than the previous
      // one, because the counter was restarted at the start-bit centre.
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_perr_nxt    = 1'b0;
            w_ferr_nxt    = 1'b0;
            w_state_nxt   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      // Odd parity expects an odd total of ones over data and parity bit.
      // Even parity expects an even total.
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = ((^r_shift) ^ r_rx_s) != PAR_ODD;
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt  = '0;
          w_ferr_now = r_ferr | ~r_rx_s;
          w_ferr_nxt = w_ferr_now;
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_nxt    = '0;
            w_rx_byte_nxt    = r_shift;
            w_parity_err_nxt = r_perr;
            w_frame_err_nxt  = w_ferr_now;
            w_byte_valid_nxt = 1'b1;
            w_receiving_nxt  = 1'b0;
            // A low stop bit may be a line held in break. Wait for the line
            // to return high, so it is not decoded again as 0x00 frames.
            w_state_nxt      = w_ferr_now ? S_BREAK : S_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      S_BREAK: begin
        w_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_byte        = r_rx_byte;
  assign byte_valid     = r_byte_valid;
  assign receiving_byte = r_receiving;
  assign parity_err     = r_parity_err;
  assign frame_err      = r_frame_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_uart_rx_simple.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_simple
//   Bench for uart_rx_simple at 10 clocks per bit. There are three instances:
//     u0 : no parity, 1 stop bit
//     u1 : even parity, 2 stop bits
//     u2 : odd parity, 1 stop bit
//   Each instance has its own serial line and expected queue. The stimulus
//   pushes {byte, perr, ferr} when it sends a frame. A monitor pops and
//   compares on every byte_valid.
// -----------------------------------------------------------------------------
module tb_uart_rx_simple;

  localparam int CPB = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       sr0 = 1'b1, sr1 = 1'b1, sr2 = 1'b1;
  logic [7:0] rb0, rb1, rb2;
  logic       bv0, bv1, bv2;
  logic       rc0, rc1, rc2;
  logic       pe0, pe1, pe2;
  logic       fe0, fe1, fe2;
  logic [2:0] st0, st1, st2;

  uart_rx_simple #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .PARITY(0), .STOP(1)) u0 (
    .clk(clk), .rst(rst), .serial_rx(sr0), .rx_byte(rb0), .byte_valid(bv0),
    .receiving_byte(rc0), .parity_err(pe0), .frame_err(fe0), .dbg_state(st0));

  uart_rx_simple #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .PARITY(2), .STOP(2)) u1 (
    .clk(clk), .rst(rst), .serial_rx(sr1), .rx_byte(rb1), .byte_valid(bv1),
    .receiving_byte(rc1), .parity_err(pe1), .frame_err(fe1), .dbg_state(st1));

  uart_rx_simple #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .PARITY(1), .STOP(1)) u2 (
    .clk(clk), .rst(rst), .serial_rx(sr2), .rx_byte(rb2), .byte_valid(bv2),
    .receiving_byte(rc2), .parity_err(pe2), .frame_err(fe2), .dbg_state(st2));

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];

  int total = 0;
  int bad   = 0;

  bit lat_armed  = 1'b0;
  int lat_start  = 0;
  bit glitch_win = 1'b0;
  bit recv_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic on_strobe(input int id, input logic [9:0] act);
    logic [9:0] e;
    bit         have;
    e    = '0;
    have = 1'b0;
    case (id)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      total++;
      bad++;
      $display("FAIL strobe_u%0d: unexpected strobe byte=%0h perr=%0b ferr=%0b, none expected (t=%0t)",
               id, act[9:2], act[1], act[0], $time);
    end else begin
      check($sformatf("strobe_u%0d {byte,perr,ferr}", id), 32'(act), 32'(e));
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bv0) begin
      on_strobe(0, {rb0, pe0, fe0});
      if (lat_armed) begin
        check("latency_u0", 32'(cyc - lat_start), 32'd97);
        lat_armed = 1'b0;
      end
    end
    if (bv1) on_strobe(1, {rb1, pe1, fe1});
    if (bv2) on_strobe(2, {rb2, pe2, fe2});
    if (glitch_win && rc0) recv_seen = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called from the falling-edge context)
  // ---------------------------------------------------------------------------
  task automatic drive_line(input int id, input logic v, input int nclk);
    case (id)
      0: sr0 = v;
      1: sr1 = v;
      default: sr2 = v;
    endcase
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input bit use_par,
                            input logic pbit, input int nstop, input logic last_stop);
    drive_line(id, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_line(id, d[i], CPB);
    if (use_par) drive_line(id, pbit, CPB);
    for (int i = 0; i < nstop; i++)
      drive_line(id, (i == nstop - 1) ? last_stop : 1'b1, CPB);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_u0", 32'({rb0, bv0, rc0, pe0, fe0, st0}), 32'd0);
    check("reset_u1", 32'({rb1, bv1, rc1, pe1, fe1, st1}), 32'd0);
    check("reset_u2", 32'({rb2, bv2, rc2, pe2, fe2, st2}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single 0xA5 frame, latency and receiving_byte window
    exp_q0.push_back({8'hA5, 1'b0, 1'b0});
    lat_start = cyc + 1;
    lat_armed = 1'b1;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
      begin
        repeat (30) @(negedge clk);
        check("recv_mid_frame", 32'(rc0), 32'd1);
      end
    join
    drive_line(0, 1'b1, 2 * CPB);
    check("recv_after_frame", 32'(rc0), 32'd0);
    check("latency_seen", 32'(lat_armed), 32'd0);
    check("hold_a5", 32'(rb0), 32'hA5);

    // 2: back-to-back frames with no idle gap
    exp_q0.push_back({8'h00, 1'b0, 1'b0});
    exp_q0.push_back({8'hFF, 1'b0, 1'b0});
    exp_q0.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    drive_line(0, 1'b1, 2 * CPB);

    // 3: parity. 0x07 has three ones.
    exp_q1.push_back({8'h07, 1'b1, 1'b0});  // even, parity bit 0 -> error
    send_frame(1, 8'h07, 1'b1, 1'b0, 2, 1'b1);
    exp_q1.push_back({8'h07, 1'b0, 1'b0});  // even, parity bit 1 -> ok
    send_frame(1, 8'h07, 1'b1, 1'b1, 2, 1'b1);
    exp_q2.push_back({8'h07, 1'b0, 1'b0});  // odd, parity bit 0 -> ok
    send_frame(2, 8'h07, 1'b1, 1'b0, 1, 1'b1);
    exp_q2.push_back({8'h07, 1'b1, 1'b0});  // odd, parity bit 1 -> error
    send_frame(2, 8'h07, 1'b1, 1'b1, 1, 1'b1);
    drive_line(1, 1'b1, 2 * CPB);
    drive_line(2, 1'b1, 2 * CPB);

    // 4: second stop bit low, then line held low for 50 bits
    exp_q1.push_back({8'h81, 1'b0, 1'b1});
    send_frame(1, 8'h81, 1'b1, 1'b0, 2, 1'b0);
    drive_line(1, 1'b0, 50 * CPB);
    check("break_state_u1", 32'(st1), 32'd5);
    drive_line(1, 1'b1, 2 * CPB);
    check("break_exit_u1", 32'(st1), 32'd0);
    check("ferr_hold_u1", 32'(fe1), 32'd1);
    exp_q1.push_back({8'h42, 1'b0, 1'b0});
    send_frame(1, 8'h42, 1'b1, 1'b0, 2, 1'b1);
    drive_line(1, 1'b1, 2 * CPB);

    // 5: 3-clock glitch on an idle line
    recv_seen  = 1'b0;
    glitch_win = 1'b1;
    drive_line(0, 1'b0, 3);
    drive_line(0, 1'b1, 3 * CPB);
    glitch_win = 1'b0;
    check("glitch_recv", 32'(recv_seen), 32'd0);
    check("glitch_state", 32'(st0), 32'd0);

    // 6: reset in the middle of DATA, then a clean frame
    drive_line(0, 1'b0, CPB);
    drive_line(0, 1'b1, CPB);
    drive_line(0, 1'b1, CPB);
    drive_line(0, 1'b0, 4);
    check("recv_before_rst", 32'(rc0), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_frame", 32'({rb0, bv0, rc0, pe0, fe0, st0}), 32'd0);
    sr0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_line(0, 1'b1, 2 * CPB);
    exp_q0.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
    drive_line(0, 1'b1, 3 * CPB);

    check("leftover_u0", 32'(exp_q0.size()), 32'd0);
    check("leftover_u1", 32'(exp_q1.size()), 32'd0);
    check("leftover_u2", 32'(exp_q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
